// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, the MEM-stage
// access state encoding and the writeback bundle.
package mips_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int DATA_W              = 32;
  localparam int DEFAULT_ADDR_OFFSET = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     result;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// external data memory (slave).
interface mem_wb_stage_if #(
  parameter int ADDR_W = 16
);
  import mips_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures a new writeback bundle when told to,
// otherwise inserts a bubble by clearing only the write enable.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  wb_bundle_t            next,
  output logic                  WB_EN,
  output logic [REG_ADDR_W-1:0] Dst_WB,
  output logic [DATA_W-1:0]     Result_WB
);

  wb_bundle_t wb_q;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (load) begin
      wb_q <= next;
    end else begin
      wb_q.wb_en <= 1'b0;
    end
  end

  assign WB_EN     = wb_q.wb_en;
  assign Dst_WB    = wb_q.dst;
  assign Result_WB = wb_q.result;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory-access / writeback stage with data-memory handshake and upstream
// freeze. Define MEM_TIMEOUT_EN to abort accesses not acknowledged in time.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int          ADDR_W         = 16,
  parameter int unsigned ADDR_OFFSET    = DEFAULT_ADDR_OFFSET,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  input  logic [DATA_W-1:0]     ALU_Result,
  input  logic [DATA_W-1:0]     Store_Val,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  output logic                  WB_EN_MEM,
  output logic [REG_ADDR_W-1:0] Dest_MEM,
  output logic                  Freeze_MEM,
  mem_wb_stage_if.master        dmem,
  output logic                  WB_EN,
  output logic [REG_ADDR_W-1:0] Dst_WB,
  output logic [DATA_W-1:0]     Result_WB,
  output logic                  mem_err
);

  if (TIMEOUT_CYCLES < 1 || ADDR_W > DATA_W - 2) begin : g_param_check
    $error("mem_wb_stage: TIMEOUT_CYCLES must be >= 1 and ADDR_W <= 30");
  end

  mem_state_e            state_q, state_d;
  logic                  req_q, we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  lat_wb_en_q;
  logic [REG_ADDR_W-1:0] lat_dst_q;

  logic                  access;
  logic                  start;
  logic                  freeze;
  logic                  timeout_hit;
  logic                  wb_load;
  wb_bundle_t            wb_next;
  logic [ADDR_W-1:0]     word_addr;

  assign access    = MEM_R_EN | MEM_W_EN;
  assign word_addr = ADDR_W'((ALU_Result - DATA_W'(ADDR_OFFSET)) >> 2);

  assign WB_EN_MEM = WB_EN_in;
  assign Dest_MEM  = Dest_in;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // The counter holds the number of already-elapsed unacknowledged BUSY
  // cycles, so the limit is reached during the TIMEOUT_CYCLES-th BUSY cycle.
  assign timeout_hit = (state_q == BUSY) && !dmem.mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= '0;
      end else if (state_q == BUSY && !dmem.mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    start          = 1'b0;
    freeze         = 1'b0;
    wb_load        = 1'b0;
    wb_next.wb_en  = WB_EN_in;
    wb_next.dst    = Dest_in;
    wb_next.result = ALU_Result;

    case (state_q)
      IDLE: begin
        if (access) begin
          start   = 1'b1;
          freeze  = 1'b1;
          state_d = BUSY;
        end else begin
          wb_load = 1'b1;
        end
      end
      BUSY: begin
        if (dmem.mem_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_load        = 1'b1;
            wb_next.wb_en  = lat_wb_en_q;
            wb_next.dst    = lat_dst_q;
            wb_next.result = dmem.mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing upstream needs holding while the stage itself is in reset.
  assign Freeze_MEM = rst & freeze;

  // Request fields are captured once at access start and held until done;
  // both-enables-set falls out as a write because mem_we follows MEM_W_EN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_wb_en_q <= 1'b0;
      lat_dst_q   <= '0;
    end else begin
      req_q <= (state_d == BUSY);
      if (start) begin
        we_q        <= MEM_W_EN;
        addr_q      <= word_addr;
        wdata_q     <= Store_Val;
        lat_wb_en_q <= WB_EN_in;
        lat_dst_q   <= Dest_in;
      end
    end
  end

  assign dmem.mem_req   = req_q;
  assign dmem.mem_we    = we_q;
  assign dmem.mem_addr  = addr_q;
  assign dmem.mem_wdata = wdata_q;

  mem_wb_reg u_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (wb_load),
    .next      (wb_next),
    .WB_EN     (WB_EN),
    .Dst_WB    (Dst_WB),
    .Result_WB (Result_WB)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; with MEM_TIMEOUT_EN defined
// it also exercises the timeout abort with a limit of 4 cycles.
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int ADDR_W = 16;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  WB_EN_in, MEM_R_EN, MEM_W_EN;
  logic [DATA_W-1:0]     ALU_Result, Store_Val;
  logic [REG_ADDR_W-1:0] Dest_in;
  logic                  WB_EN_MEM, Freeze_MEM, WB_EN, mem_err;
  logic [REG_ADDR_W-1:0] Dest_MEM, Dst_WB;
  logic [DATA_W-1:0]     Result_WB;

  mem_wb_stage_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_wb_stage #(
    .ADDR_W         (ADDR_W),
    .ADDR_OFFSET    (1024),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .WB_EN_in   (WB_EN_in),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_Result (ALU_Result),
    .Store_Val  (Store_Val),
    .Dest_in    (Dest_in),
    .WB_EN_MEM  (WB_EN_MEM),
    .Dest_MEM   (Dest_MEM),
    .Freeze_MEM (Freeze_MEM),
    .dmem       (dmem.master),
    .WB_EN      (WB_EN),
    .Dst_WB     (Dst_WB),
    .Result_WB  (Result_WB),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int w, input int wb, input int d,
                       input logic [31:0] alu, input logic [31:0] sv);
    MEM_R_EN   = r[0];
    MEM_W_EN   = w[0];
    WB_EN_in   = wb[0];
    Dest_in    = 5'(d);
    ALU_Result = alu;
    Store_Val  = sv;
  endtask

  task automatic set_ack(input int a, input logic [31:0] rd);
    dmem.mem_ack   = a[0];
    dmem.mem_rdata = rd;
  endtask

  int fz;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    set_ack(0, 0);

    // Reset values
    repeat (2) tick();
    check("rst_wb_en",  32'(WB_EN), 0);
    check("rst_req",    32'(dmem.mem_req), 0);
    check("rst_result", Result_WB, 0);
    check("rst_freeze", 32'(Freeze_MEM), 0);
    check("rst_err",    32'(mem_err), 0);
    rst = 1'b1;
    tick();

    // Plain ALU op: one-cycle writeback, no freeze
    drive(0, 0, 1, 5, 32'h0000_002A, 0);
    #1;
    check("alu_freeze",  32'(Freeze_MEM), 0);
    check("alu_wbenmem", 32'(WB_EN_MEM), 1);
    check("alu_destmem", 32'(Dest_MEM), 5);
    tick();
    check("alu_wb_en",  32'(WB_EN), 1);
    check("alu_dst",    32'(Dst_WB), 5);
    check("alu_result", Result_WB, 32'h2A);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("nop_wb_en", 32'(WB_EN), 0);

    // Spurious ack in IDLE is ignored
    drive(0, 0, 1, 9, 32'h100, 0);
    set_ack(1, 32'hBAD);
    #1;
    check("idle_ack_freeze", 32'(Freeze_MEM), 0);
    tick();
    set_ack(0, 0);
    check("idle_ack_result", Result_WB, 32'h100);
    check("idle_ack_dst",    32'(Dst_WB), 9);
    check("idle_ack_req",    32'(dmem.mem_req), 0);

    // Load at 1032, ack in 4th BUSY cycle, followed by an ALU op
    fz = 0;
    drive(1, 0, 1, 8, 32'd1032, 32'hFFFF);
    #1;
    check("ld_freeze_idle", 32'(Freeze_MEM), 1);
    if (Freeze_MEM) fz++;
    tick();
    check("ld_req",   32'(dmem.mem_req), 1);
    check("ld_addr",  32'(dmem.mem_addr), 2);
    check("ld_we",    32'(dmem.mem_we), 0);
    check("ld_wb_en", 32'(WB_EN), 0);
    drive(0, 1, 0, 31, 32'hDEAD_BEEF, 32'h5555);
    #1;
    check("ld_passthru", 32'(WB_EN_MEM), 0);
    for (int i = 0; i < 3; i++) begin
      check("ld_freeze_busy", 32'(Freeze_MEM), 1);
      if (Freeze_MEM) fz++;
      tick();
      check("ld_addr_held", 32'(dmem.mem_addr), 2);
      check("ld_we_held",   32'(dmem.mem_we), 0);
      check("ld_bubble",    32'(WB_EN), 0);
    end
    set_ack(1, 32'hCAFE_F00D);
    #1;
    check("ld_freeze_ack", 32'(Freeze_MEM), 0);
    if (Freeze_MEM) fz++;
    check("ld_freeze_cycles", 32'(fz), 4);
    tick();
    set_ack(0, 0);
    check("ld_wb_en",   32'(WB_EN), 1);
    check("ld_dst",     32'(Dst_WB), 8);
    check("ld_result",  Result_WB, 32'hCAFE_F00D);
    check("ld_req_off", 32'(dmem.mem_req), 0);
    drive(0, 0, 1, 3, 32'h77, 0);
    #1;
    check("b2b_freeze", 32'(Freeze_MEM), 0);
    tick();
    check("b2b_wb_en",  32'(WB_EN), 1);
    check("b2b_dst",    32'(Dst_WB), 3);
    check("b2b_result", Result_WB, 32'h77);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("b2b_no_dup", 32'(WB_EN), 0);

    // Store at 1028, ack in first BUSY cycle
    drive(0, 1, 0, 0, 32'd1028, 32'h1234);
    #1;
    check("st_freeze_idle", 32'(Freeze_MEM), 1);
    tick();
    check("st_req",   32'(dmem.mem_req), 1);
    check("st_we",    32'(dmem.mem_we), 1);
    check("st_addr",  32'(dmem.mem_addr), 1);
    check("st_wdata", dmem.mem_wdata, 32'h1234);
    check("st_wb_en", 32'(WB_EN), 0);
    set_ack(1, 32'h4444);
    #1;
    check("st_freeze_ack", 32'(Freeze_MEM), 0);
    tick();
    set_ack(0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("st_req_off", 32'(dmem.mem_req), 0);
    check("st_no_wb",   32'(WB_EN), 0);

    // Both enables set behaves as a store
    drive(1, 1, 1, 4, 32'd1064, 32'hA5A5);
    tick();
    check("rw_we",    32'(dmem.mem_we), 1);
    check("rw_addr",  32'(dmem.mem_addr), 10);
    check("rw_wdata", dmem.mem_wdata, 32'hA5A5);
    set_ack(1, 32'h99);
    tick();
    set_ack(0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("rw_no_wb", 32'(WB_EN), 0);

    // Address below the offset wraps modulo 2^32
    drive(1, 0, 1, 7, 32'd0, 0);
    tick();
    check("wrap_addr", 32'(dmem.mem_addr), 32'hFF00);
    set_ack(1, 32'h55);
    tick();
    set_ack(0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("wrap_wb_en",  32'(WB_EN), 1);
    check("wrap_dst",    32'(Dst_WB), 7);
    check("wrap_result", Result_WB, 32'h55);

    // Reset during BUSY abandons the access
    drive(1, 0, 1, 6, 32'd1040, 0);
    tick();
    check("rb_req_busy", 32'(dmem.mem_req), 1);
    rst = 1'b0;
    #1;
    check("rb_req",    32'(dmem.mem_req), 0);
    check("rb_wb_en",  32'(WB_EN), 0);
    check("rb_freeze", 32'(Freeze_MEM), 0);
    check("rb_addr",   32'(dmem.mem_addr), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    set_ack(1, 32'h1111);
    #1;
    check("rb_ack_freeze", 32'(Freeze_MEM), 0);
    tick();
    set_ack(0, 0);
    check("rb_ack_no_wb",  32'(WB_EN), 0);
    check("rb_ack_no_req", 32'(dmem.mem_req), 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 BUSY cycles, sticky error
    drive(1, 0, 1, 2, 32'd1100, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      check("to_req_busy", 32'(dmem.mem_req), 1);
      check("to_freeze",   32'(Freeze_MEM), (i < TMO - 1) ? 1 : 0);
      check("to_err_low",  32'(mem_err), 0);
      tick();
    end
    check("to_req_off", 32'(dmem.mem_req), 0);
    check("to_err",     32'(mem_err), 1);
    check("to_wb_en",   32'(WB_EN), 0);
    drive(0, 0, 1, 1, 32'h9, 0);
    repeat (2) tick();
    check("to_err_sticky", 32'(mem_err), 1);
    check("to_alu_after",  Result_WB, 32'h9);
`else
    repeat (2) tick();
    check("no_timeout_err", 32'(mem_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
